// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data ports), the shared
// single-port SRAM macro and the arbiter that sits in the middle.
interface imem_dmem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  // Instruction-fetch port (read only)
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_stall;

  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_stall;

  // SRAM macro side (active-low strobes, registered Q)
  logic          mem_cen_n;
  logic          mem_wen_n;
  logic          mem_oen_n;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  // Environment view: pipeline requesters plus the SRAM returning mem_q
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  i_gnt, i_rvalid, i_rdata, i_stall,
           d_gnt, d_rvalid, d_rdata, d_stall,
           mem_cen_n, mem_wen_n, mem_oen_n, mem_a, mem_d
  );

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output i_gnt, i_rvalid, i_rdata, i_stall,
           d_gnt, d_rvalid, d_rdata, d_stall,
           mem_cen_n, mem_wen_n, mem_oen_n, mem_a, mem_d
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and
// data access. Data wins by default; fetch is forced through after
// STARVE_LIMIT consecutive denied cycles. Reads return one cycle after grant.
module imem_dmem_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD_I = 2'd1;
  localparam logic [1:0] ST_RD_D = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  // Saturating increment for the 4-bit starvation counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] i_hold_q, i_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;
  logic [AW-1:0] a_hold_q, a_hold_d;
  logic [DW-1:0] wd_hold_q, wd_hold_d;

  logic force_i;
  logic i_gnt;
  logic d_gnt;
  logic i_rvalid;
  logic d_rvalid;

  // Grant decision: data priority, fetch forced once starved; nothing in reset
  always_comb begin
    force_i = (starve_cnt_q >= STARVE_LIM);
    d_gnt   = ~rst & bus.d_req & ~force_i;
    i_gnt   = ~rst & bus.i_req & (~bus.d_req | force_i);
  end

  // Next-state for counter, read-owner FSM and the hold registers
  always_comb begin
    i_rvalid = (state_q == ST_RD_I);
    d_rvalid = (state_q == ST_RD_D);

    if (bus.i_req && !i_gnt) starve_cnt_d = sat_inc4(starve_cnt_q);
    else                     starve_cnt_d = 4'd0;

    if (d_gnt && !bus.d_we) state_d = ST_RD_D;
    else if (i_gnt)         state_d = ST_RD_I;
    else                    state_d = ST_IDLE;

    i_hold_d = i_rvalid ? bus.mem_q : i_hold_q;
    d_hold_d = d_rvalid ? bus.mem_q : d_hold_q;

    // Address/data to the macro only move on a grant, so idle cycles don't toggle them
    if (d_gnt)      a_hold_d = bus.d_addr;
    else if (i_gnt) a_hold_d = bus.i_addr;
    else            a_hold_d = a_hold_q;
    wd_hold_d = d_gnt ? bus.d_wdata : wd_hold_q;
  end

  // Control state and read-data holding registers (reset to known values)
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      state_q      <= ST_IDLE;
      i_hold_q     <= '0;
      d_hold_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      state_q      <= state_d;
      i_hold_q     <= i_hold_d;
      d_hold_q     <= d_hold_d;
    end
  end

  // SRAM address/write-data hold; pure datapath, no reset needed
  always_ff @(posedge clk) begin
    a_hold_q  <= a_hold_d;
    wd_hold_q <= wd_hold_d;
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_stall   = ~rst & bus.i_req & ~i_gnt;
  assign bus.d_stall   = ~rst & bus.d_req & ~d_gnt;

  assign bus.mem_cen_n = ~(i_gnt | d_gnt);
  assign bus.mem_wen_n = ~(d_gnt & bus.d_we);
  assign bus.mem_oen_n = ~(i_rvalid | d_rvalid);
  assign bus.mem_a     = a_hold_d;
  assign bus.mem_d     = wd_hold_d;

  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rvalid ? bus.mem_q : i_hold_q;
  assign bus.d_rdata   = d_rvalid ? bus.mem_q : d_hold_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural RAM2Kx32 model.
module tb_imem_dmem_arbiter;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  imem_dmem_arbiter_if #(.AW(11), .DW(32)) bus ();

  imem_dmem_arbiter #(.AW(11), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered Q, write when CEN/WEN low, plus a backdoor preload port
  logic [31:0] sram [0:2047];
  logic        pre_we;
  logic [10:0] pre_a;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) sram[pre_a] <= pre_d;
    else if (!bus.mem_cen_n) begin
      if (!bus.mem_wen_n) sram[bus.mem_a] <= bus.mem_d;
      else                bus.mem_q <= sram[bus.mem_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nst;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    preload(11'h005, 32'h8C41_0004);
    preload(11'h010, 32'h1111_0010);
    preload(11'h020, 32'h2222_0020);

    // Reset held two edges with both requests pending
    bus.i_req = 1'b1; bus.i_addr = 11'h005;
    bus.d_req = 1'b1; bus.d_addr = 11'h005; bus.d_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_cen_n",    32'(bus.mem_cen_n), 32'd1);
      chk("rst_wen_n",    32'(bus.mem_wen_n), 32'd1);
      chk("rst_oen_n",    32'(bus.mem_oen_n), 32'd1);
      chk("rst_i_gnt",    32'(bus.i_gnt),     32'd0);
      chk("rst_d_gnt",    32'(bus.d_gnt),     32'd0);
      chk("rst_i_rvalid", 32'(bus.i_rvalid),  32'd0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid),  32'd0);
      chk("rst_i_stall",  32'(bus.i_stall),   32'd0);
      chk("rst_d_stall",  32'(bus.d_stall),   32'd0);
      chk("rst_i_rdata",  bus.i_rdata,        32'd0);
      chk("rst_d_rdata",  bus.d_rdata,        32'd0);
    end

    // Release: data wins the first cycle
    rst = 1'b0;
    #1;
    chk("rel_d_gnt",   32'(bus.d_gnt),     32'd1);
    chk("rel_i_gnt",   32'(bus.i_gnt),     32'd0);
    chk("rel_i_stall", 32'(bus.i_stall),   32'd1);
    chk("rel_d_stall", 32'(bus.d_stall),   32'd0);
    chk("rel_cen_n",   32'(bus.mem_cen_n), 32'd0);
    chk("rel_mem_a",   32'(bus.mem_a),     32'h005);
    tick();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("rel_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("rel_d_rdata",  bus.d_rdata,       32'h8C41_0004);
    chk("rel_i_rvalid", 32'(bus.i_rvalid), 32'd0);

    // Single fetch read
    tick();
    bus.i_req = 1'b1; bus.i_addr = 11'h005;
    @(negedge clk);
    chk("if_i_gnt",   32'(bus.i_gnt),     32'd1);
    chk("if_d_gnt",   32'(bus.d_gnt),     32'd0);
    chk("if_i_stall", 32'(bus.i_stall),   32'd0);
    chk("if_cen_n",   32'(bus.mem_cen_n), 32'd0);
    chk("if_wen_n",   32'(bus.mem_wen_n), 32'd1);
    tick();
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("if_i_rvalid", 32'(bus.i_rvalid),  32'd1);
    chk("if_i_rdata",  bus.i_rdata,        32'h8C41_0004);
    chk("if_oen_n",    32'(bus.mem_oen_n), 32'd0);
    chk("if_d_rvalid", 32'(bus.d_rvalid),  32'd0);
    tick();
    @(negedge clk);
    chk("if_rvalid_drop", 32'(bus.i_rvalid),  32'd0);
    chk("if_rdata_hold",  bus.i_rdata,        32'h8C41_0004);
    chk("if_oen_idle",    32'(bus.mem_oen_n), 32'd1);
    chk("if_cen_idle",    32'(bus.mem_cen_n), 32'd1);
    chk("if_mem_a_hold",  32'(bus.mem_a),     32'h005);

    // Write 0x7FF then read it back the next cycle
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h7FF; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_d_gnt", 32'(bus.d_gnt),     32'd1);
    chk("wr_wen_n", 32'(bus.mem_wen_n), 32'd0);
    chk("wr_cen_n", 32'(bus.mem_cen_n), 32'd0);
    chk("wr_mem_a", 32'(bus.mem_a),     32'h7FF);
    chk("wr_mem_d", bus.mem_d,          32'hDEAD_BEEF);
    tick();
    bus.d_we = 1'b0;
    @(negedge clk);
    chk("rd_d_gnt",     32'(bus.d_gnt),     32'd1);
    chk("rd_wen_n",     32'(bus.mem_wen_n), 32'd1);
    chk("wr_no_rvalid", 32'(bus.d_rvalid),  32'd0);
    chk("wr_oen_n",     32'(bus.mem_oen_n), 32'd1);
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("rd_d_rvalid", 32'(bus.d_rvalid),  32'd1);
    chk("rd_d_rdata",  bus.d_rdata,        32'hDEAD_BEEF);
    chk("rd_wen_idle", 32'(bus.mem_wen_n), 32'd1);

    // Contention: both ports request continuously
    tick();
    bus.i_req = 1'b1; bus.i_addr = 11'h010;
    bus.d_req = 1'b1; bus.d_addr = 11'h020; bus.d_we = 1'b0;
    nst = 0;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = ((k % 5) == 4);
      @(negedge clk);
      chk($sformatf("ct_i_gnt_%0d", k),   32'(bus.i_gnt),   32'(exp_i));
      chk($sformatf("ct_d_gnt_%0d", k),   32'(bus.d_gnt),   32'(!exp_i));
      chk($sformatf("ct_i_stall_%0d", k), 32'(bus.i_stall), 32'(!exp_i));
      chk($sformatf("ct_d_stall_%0d", k), 32'(bus.d_stall), 32'(exp_i));
      chk($sformatf("ct_i_rvalid_%0d", k), 32'(bus.i_rvalid), 32'(k > 0 && (k % 5) == 0));
      chk($sformatf("ct_d_rvalid_%0d", k), 32'(bus.d_rvalid), 32'(k > 0 && (k % 5) != 0));
      if (bus.i_stall) nst++;
      tick();
    end
    chk("ct_stall_count", 32'(nst), 32'd8);

    // Alternating I/D reads every cycle
    for (int k = 0; k < 6; k++) begin
      logic exp_iv, exp_dv;
      bus.i_req = ((k % 2) == 0);
      bus.d_req = ((k % 2) == 1);
      exp_iv = (k == 0) || ((k % 2) == 1);
      exp_dv = ((k % 2) == 0) && (k > 0);
      @(negedge clk);
      chk($sformatf("alt_i_gnt_%0d", k),    32'(bus.i_gnt),     32'((k % 2) == 0));
      chk($sformatf("alt_d_gnt_%0d", k),    32'(bus.d_gnt),     32'((k % 2) == 1));
      chk($sformatf("alt_oen_n_%0d", k),    32'(bus.mem_oen_n), 32'd0);
      chk($sformatf("alt_i_rvalid_%0d", k), 32'(bus.i_rvalid),  32'(exp_iv));
      chk($sformatf("alt_d_rvalid_%0d", k), 32'(bus.d_rvalid),  32'(exp_dv));
      if (exp_iv) chk($sformatf("alt_i_rdata_%0d", k), bus.i_rdata, 32'h1111_0010);
      if (exp_dv) chk($sformatf("alt_d_rdata_%0d", k), bus.d_rdata, 32'h2222_0020);
      tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("alt_tail_d_rvalid", 32'(bus.d_rvalid),  32'd1);
    chk("alt_tail_d_rdata",  bus.d_rdata,        32'h2222_0020);
    chk("alt_tail_i_rvalid", 32'(bus.i_rvalid),  32'd0);
    chk("alt_tail_oen_n",    32'(bus.mem_oen_n), 32'd0);

    // Reset arriving on the edge that would issue a data read
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h020;
    @(negedge clk);
    chk("mr_d_gnt", 32'(bus.d_gnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("mr_d_rvalid", 32'(bus.d_rvalid),  32'd0);
    chk("mr_d_rdata",  bus.d_rdata,        32'd0);
    chk("mr_i_rdata",  bus.i_rdata,        32'd0);
    chk("mr_oen_n",    32'(bus.mem_oen_n), 32'd1);
    chk("mr_cen_n",    32'(bus.mem_cen_n), 32'd1);
    tick();
    @(negedge clk);
    chk("mr_d_rvalid_late", 32'(bus.d_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
